// File: rtl/aurora_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Aurora 64B66B TX AXI-Stream
// port between NUM_SRC requesters. Frames are never interleaved; a frame cut
// by channel loss is drained to its tlast, discarded and counted.

// Per-source slice: masks the source onto the shared bus when granted and
// produces its tready.
module aurora_tx_arbiter_lane (
  input  logic        sel,
  input  logic        xfer,
  input  logic        flush,
  input  logic        m_ready,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic        tlast,
  input  logic        tvalid,
  output logic        tready,
  output logic [63:0] mdata,
  output logic [7:0]  mkeep,
  output logic        mlast,
  output logic        mvalid
);
  // Only the granted lane drives non-zero values, so the top can OR-reduce.
  always_comb begin
    mdata  = sel ? tdata : '0;
    mkeep  = sel ? tkeep : '0;
    mlast  = sel & tlast;
    mvalid = sel & tvalid;
    tready = sel & (flush | (xfer & m_ready));
  end
endmodule

module aurora_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_channel_up,
  input  logic [64*NUM_SRC-1:0] s_axis_tdata,
  input  logic [8*NUM_SRC-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [NUM_SRC-1:0]    o_grant,
  output logic                  o_busy,
  output logic [15:0]           o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic [NUM_SRC-1:0]        grant;
  logic [SEL_W-1:0]          gidx, rr_ptr, pick, gidx_inc;
  logic [SEL_W:0]            cand;
  logic                      any_req;
  logic [15:0]               drop_cnt;

  logic [NUM_SRC-1:0][63:0]  lane_data;
  logic [NUM_SRC-1:0][7:0]   lane_keep;
  logic [NUM_SRC-1:0]        lane_last, lane_valid;

  logic                      in_xfer, in_flush, sel_valid, sel_last;
  logic                      start, xfer_done, frame_drop, go_flush;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_lane
      aurora_tx_arbiter_lane u_lane (
        .sel    (grant[g]),
        .xfer   (in_xfer),
        .flush  (in_flush),
        .m_ready(m_axis_tready),
        .tdata  (s_axis_tdata[64*g +: 64]),
        .tkeep  (s_axis_tkeep[8*g +: 8]),
        .tlast  (s_axis_tlast[g]),
        .tvalid (s_axis_tvalid[g]),
        .tready (s_axis_tready[g]),
        .mdata  (lane_data[g]),
        .mkeep  (lane_keep[g]),
        .mlast  (lane_last[g]),
        .mvalid (lane_valid[g])
      );
    end
  endgenerate

  // OR-reduce the masked lanes into the granted source's view.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      m_axis_tdata = m_axis_tdata | lane_data[i];
      m_axis_tkeep = m_axis_tkeep | lane_keep[i];
    end
  end

  // Round-robin pick: walk offsets high to low so the nearest to rr_ptr wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_SRC)) cand = cand - (SEL_W+1)'(NUM_SRC);
      if (s_axis_tvalid[cand[SEL_W-1:0]]) begin
        pick    = cand[SEL_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Handshake decode. The granted tlast beat may still be offered in the
  // cycle the channel drops (tvalid then depends on tready) so that a frame
  // completing on that edge is not reported as dropped.
  always_comb begin
    in_xfer       = (state == XFER);
    in_flush      = (state == FLUSH);
    sel_valid     = |lane_valid;
    sel_last      = |lane_last;
    m_axis_tlast  = sel_last;
    xfer_done     = in_xfer & sel_valid & sel_last & m_axis_tready;
    m_axis_tvalid = in_xfer & sel_valid & (i_channel_up | (sel_last & m_axis_tready));
    go_flush      = in_xfer & ~i_channel_up & ~xfer_done;
    frame_drop    = in_flush & sel_valid & sel_last;
    start         = (state == IDLE) & i_channel_up & any_req;
    gidx_inc      = (gidx == SEL_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = XFER;
      XFER:    if (xfer_done) state_nxt = IDLE;
               else if (go_flush) state_nxt = FLUSH;
      FLUSH:   if (frame_drop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and round-robin pointer: latch on start, release at frame end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else if (start) begin
      grant <= NUM_SRC'(1) << pick;
      gidx  <= pick;
    end else if (xfer_done | frame_drop) begin
      grant  <= '0;
      rr_ptr <= gidx_inc;
    end
  end

  // Saturating count of frames discarded after channel loss.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            drop_cnt <= '0;
    else if (frame_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
  end

  assign o_grant    = grant;
  assign o_busy     = (state != IDLE);
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: per-source beat queues feed the DUT, expected
// output beats go to a scoreboard queue and are compared as they appear.
module tb_aurora_tx_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n, chan_up;
  logic [64*N-1:0]  s_tdata;
  logic [8*N-1:0]   s_tkeep;
  logic [N-1:0]     s_tlast, s_tvalid, s_tready;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tkeep;
  logic             m_tlast, m_tvalid, m_tready;
  logic [N-1:0]     grant;
  logic             busy;
  logic [15:0]      drop_cnt;

  aurora_tx_arbiter #(.NUM_SRC(N), .SEL_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_channel_up(chan_up),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .o_grant(grant), .o_busy(busy), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [72:0] beat_t;   // {data, keep, last}
  typedef struct {
    int           src;
    int           len;
    bit           tog;
    logic [N-1:0] exp_grant;
    int           exp_cyc;
  } vec_t;

  beat_t        srcq[N][$];
  beat_t        expq[$];
  logic [N-1:0] ghist[$];
  int           pass_cnt = 0, chk_cnt = 0;
  logic         toggle = 1'b0, cnt_bub = 1'b0;
  logic [N-1:0] fire, watch_grant, last_grant;
  int           gcnt = 0, bubbles = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mk(int src, int fr, int b, bit last);
    logic [63:0] d;
    d = {8'(8'hA0 + src), 8'(fr), 16'hC0DE, 24'h0, 8'(b)};
    return {d, (last ? 8'h0F : 8'hFF), last};
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        {s_tdata[64*k +: 64], s_tkeep[8*k +: 8], s_tlast[k]} = srcq[k][0];
        s_tvalid[k] = 1'b1;
      end else begin
        s_tdata[64*k +: 64] = '0;
        s_tkeep[8*k +: 8]   = '0;
        s_tlast[k]          = 1'b0;
        s_tvalid[k]         = 1'b0;
      end
    end
  endtask

  // Queue a frame on a source; the first nexp beats are expected on m_axis.
  task automatic add_frame(int src, int fr, int len, int nexp);
    for (int b = 0; b < len; b++) begin
      srcq[src].push_back(mk(src, fr, b, b == len - 1));
      if (b < nexp) expq.push_back(mk(src, fr, b, b == len - 1));
    end
    drive_srcs();
  endtask

  // One clock: observe at negedge, then update stimulus 1 after posedge.
  task automatic tick();
    @(negedge clk);
    fire = s_tvalid & s_tready;
    if (m_tvalid) begin
      if (expq.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
      end else begin
        chk("beat", {m_tdata, m_tkeep, m_tlast}, expq[0]);
        if (m_tready) void'(expq.pop_front());
      end
    end
    if (grant != 0 && chan_up) chk("tready_mirror", s_tready, grant & {N{m_tready}});
    if (grant == watch_grant) gcnt++;
    if (grant != 0 && grant != last_grant) ghist.push_back(grant);
    last_grant = grant;
    if (cnt_bub && !busy && expq.size() > 0) bubbles++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (fire[k]) void'(srcq[k].pop_front());
    if (toggle) m_tready = ~m_tready;
    drive_srcs();
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    chk("wait_busy", busy, 1'b1);
  endtask

  task automatic run_idle(int maxc);
    int n = 0;
    do begin tick(); n++; end while ((expq.size() > 0 || busy) && n < maxc);
    chk("drain", {expq.size() != 0, busy}, 2'b00);
  endtask

  task automatic chk_quiet(string name);
    chk({name, "_grant"}, grant, '0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_mvalid"}, m_tvalid, 1'b0);
    chk({name, "_sready"}, s_tready, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         vt[4];
    logic [N-1:0] ord[5];
    vt[0] = '{src: 0, len: 3, tog: 1'b0, exp_grant: 4'b0001, exp_cyc: 3};
    vt[1] = '{src: 2, len: 4, tog: 1'b1, exp_grant: 4'b0100, exp_cyc: 8};
    vt[2] = '{src: 1, len: 2, tog: 1'b1, exp_grant: 4'b0010, exp_cyc: 4};
    vt[3] = '{src: 3, len: 1, tog: 1'b0, exp_grant: 4'b1000, exp_cyc: 1};
    ord   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; chan_up = 1'b0; m_tready = 1'b1;
    watch_grant = 4'hF; last_grant = '0; fire = '0;
    drive_srcs();
    #2;
    chk_quiet("reset");
    chk("reset_drop", drop_cnt, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; chan_up = 1'b1;

    // Single frames: grant and cycles spent granted, with and without stalls.
    for (int i = 0; i < 4; i++) begin
      m_tready = 1'b1; toggle = vt[i].tog;
      watch_grant = vt[i].exp_grant; gcnt = 0;
      add_frame(vt[i].src, i, vt[i].len, vt[i].len);
      run_idle(60);
      chk("xfer_cycles", gcnt, vt[i].exp_cyc);
      toggle = 1'b0; m_tready = 1'b1; watch_grant = 4'hF;
    end
    chk("no_drop", drop_cnt, 16'd0);

    // Channel loss on beat 2 of a 5-beat frame from src1.
    add_frame(1, 10, 5, 1);
    wait_busy();
    tick();
    chan_up = 1'b0;
    #1;
    chk("drop_mvalid", m_tvalid, 1'b0);
    chk("drop_sready", s_tready, 4'b0010);
    run_idle(20);
    chk("drop_cnt", drop_cnt, 16'd1);

    // Requests wait while the channel is down; src2 wins once it returns.
    add_frame(2, 12, 2, 2);
    add_frame(0, 11, 2, 2);
    repeat (3) tick();
    chk("down_busy", busy, 1'b0);
    chk("down_grant", grant, '0);
    chan_up = 1'b1;
    run_idle(30);

    // Channel falls on the same cycle src0's tlast is accepted.
    add_frame(0, 20, 2, 2);
    wait_busy();
    tick();
    chan_up = 1'b0;
    #1;
    chk("tie_mvalid", m_tvalid, 1'b1);
    tick();
    chk("tie_busy", busy, 1'b0);
    chk("tie_drop", drop_cnt, 16'd1);
    chan_up = 1'b1;

    // Asynchronous reset in the middle of a frame.
    add_frame(3, 30, 4, 1);
    wait_busy();
    tick();
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_drop", drop_cnt, 16'd0);
    srcq[3].delete();
    expq.delete();
    drive_srcs();
    tick(); tick();
    rst_n = 1'b1;

    // Fairness after reset: grant order 0,1,2,3,0 with one idle cycle between.
    ghist.delete();
    add_frame(0, 40, 2, 2);
    add_frame(1, 41, 2, 2);
    add_frame(2, 42, 2, 2);
    add_frame(3, 43, 2, 2);
    add_frame(0, 44, 2, 2);
    wait_busy();
    bubbles = 0; cnt_bub = 1'b1;
    run_idle(60);
    cnt_bub = 1'b0;
    chk("bubbles", bubbles, 4);
    chk("grant_count", ghist.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < ghist.size()) chk("grant_order", ghist[i], ord[i]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Frame-level round-robin arbiter that shares the single Aurora 64B66B TX AXI-Stream port between NUM_SRC independent requesters.
- Sits in the user_clk domain, directly ahead of the channel wrapper's s_axi_tx_* inputs.
- Grants the link only while the channel is up and never interleaves beats of different frames.
- If the channel drops mid-frame, it drains and discards the remainder of the in-flight frame and counts the drop.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- SEL_W, 2, grant index width; must equal clog2(NUM_SRC).

Ports:
- i_clk  in  1  user clock (the channel's user_clk).
- i_rst_n  in  1  asynchronous reset, active low.
- i_channel_up  in  1  channel_up from the Aurora channel; treated as synchronous to i_clk.
- s_axis_tdata  in  64*NUM_SRC  source data; source k occupies bits [64k+63:64k].
- s_axis_tkeep  in  8*NUM_SRC  source byte enables; source k occupies bits [8k+7:8k].
- s_axis_tlast  in  NUM_SRC  per-source end of frame.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  64  data to the channel TX port.
- m_axis_tkeep  out  8  byte enables to the channel TX port.
- m_axis_tlast  out  1  end of frame to the channel TX port.
- m_axis_tvalid  out  1  valid to the channel TX port.
- m_axis_tready  in  1  tready from the channel TX port.
- o_grant  out  NUM_SRC  one-hot current owner; 0 when idle.
- o_busy  out  1  high in XFER or FLUSH.
- o_drop_cnt  out  16  frames aborted by channel loss; saturates at 0xFFFF.

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE, rr_ptr=0, o_grant=0, all s_axis_tready=0, m_axis_tvalid=0, o_busy=0, o_drop_cnt=0.
- State register encodes IDLE, XFER and FLUSH; grant and rr_ptr are registers.
- IDLE:
  - If i_channel_up=1 and any s_axis_tvalid=1, select the first valid source searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ...).
  - Register the selection as the grant and go to XFER on the next edge.
  - Otherwise stay in IDLE.
  - All outputs are quiet in IDLE: m_axis_tvalid=0, s_axis_tready=0.
- XFER: combinational pass-through of the granted source, zero latency.
  - m_axis_tdata/tkeep/tlast/tvalid = the granted source's signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready are 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - Accepted beat with tlast=1: rr_ptr = g+1 (mod NUM_SRC), grant cleared, next state IDLE.
  - Consequence: one bubble cycle between consecutive frames.
  - The grant is held until that tlast regardless of other requests.
  - Bubbles in the source's tvalid keep the grant.
- Channel loss:
  - If i_channel_up=0 is sampled in XFER and the same cycle is not a completing tlast beat, go to FLUSH.
  - From that cycle onward m_axis_tvalid=0.
  - An accepted tlast beat in the same cycle wins: the frame completes, go to IDLE, no drop is counted.
- FLUSH:
  - m_axis_tvalid=0 and s_axis_tready[g]=1; the granted source's beats are discarded.
  - On a discarded beat with tlast=1: o_drop_cnt += 1 (saturating), rr_ptr = g+1, next state IDLE.
  - FLUSH does not exit on channel return; the frame is always drained to its tlast.
- Channel down in IDLE: no grant is issued and requests wait. Source tvalid/data must be held stable per AXI-Stream.
- o_busy = (state != IDLE).
- o_grant is one-hot of g in XFER/FLUSH and 0 otherwise.
- Single-beat frames (tlast on the first beat) are legal: IDLE→XFER→IDLE in 2 cycles.
- No tkeep checking or modification is performed; tkeep is passed through unchanged.

Test Plan:
- Single source: src0 sends a 3-beat frame, m_tready=1, channel up → m_axis carries 3 beats in order with tlast on beat 3; o_grant=0001 for exactly 3 cycles; o_drop_cnt=0.
- Fairness: all 4 sources continuously valid with 2-beat frames → grant order 0,1,2,3,0 with one idle cycle between frames; no beat interleaving.
- Backpressure: src2 sends a 4-beat frame while m_tready toggles 1,0,1,0... → 8 cycles in XFER; s_axis_tready[2] mirrors m_tready; data unchanged while stalled.
- Channel drop: src1 on beat 2 of a 5-beat frame, i_channel_up→0 → m_tvalid=0 from that cycle; remaining 3 beats consumed with s_tready[1]=1; o_drop_cnt=1; next grant goes to src2 once the channel is back up.
- Tie on tlast: i_channel_up falls in the same cycle as src0's accepted tlast → frame completes, state IDLE, o_drop_cnt=0.
- Reset mid-frame: assert i_rst_n=0 during XFER → all outputs 0 immediately (asynchronous); after release rr_ptr=0, so src0 is chosen first if valid.
